scarf_trigger_mc: RTL and testbench
===================================

SCARF_TRIGGER_MC -- requirements
Module: scarf_trigger_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of trigger source channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of the pulse-width and holdoff counters.
REQ-003 SHALL have parameter PRESC_W, default 8, width of the time-base prescaler.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports: clk  input  1  clock; rst_sync  input  1  synchronous active-high reset.
REQ-005 SHALL have trig_src  input  NUM_CH  asynchronous trigger sources.
REQ-006 SHALL have cfg_enable  input  1  block enable; cfg_ch_en  input  NUM_CH  per-channel enable; cfg_positive  input  NUM_CH  per-channel active-high pulse select.
REQ-007 SHALL have cfg_type  input  3  qualifier type 0..4; cfg_min, cfg_max  input  CNT_W  width limits in ticks; cfg_prescale  input  PRESC_W  tick period minus one.
REQ-008 SHALL have cfg_timeout  input  1  timeout mode; cfg_and  input  1  combine mode, 0=OR, 1=AND; cfg_holdoff  input  CNT_W  holdoff clocks; cfg_auto_rearm  input  1.
REQ-009 SHALL have arm  input  1  one-cycle arm request.
REQ-010 SHALL have trigger_out  output  1  one-cycle trigger pulse; armed  output  1; trig_ch  output  NUM_CH  channels that caused the last trigger; trig_count  output  16  triggers since reset.

Function
REQ-011 Each channel SHALL pass through a 2-flop synchronizer; if cfg_positive=0, the channel SHALL be inverted so that the active level is 1.
REQ-012 The prescaler SHALL assert a tick every cfg_prescale+1 clocks; cfg_prescale=0 SHALL tick every clock.
REQ-013 The per-channel width counter SHALL clear on the active edge, increment on each tick while active, and saturate at all-ones.
REQ-014 On the inactive edge, width W SHALL qualify per cfg_type: 0 any edge; 1 W<cfg_min; 2 W>cfg_min; 3 cfg_min<W<cfg_max; 4 W<cfg_min or W>cfg_max; types 5-7 never qualify.
REQ-015 With cfg_timeout=1 and type 2 or 4, a channel SHALL qualify once per pulse, in the cycle its counter first exceeds the threshold (cfg_min for type 2, cfg_max for type 4); its later inactive edge SHALL NOT qualify again.
REQ-016 The FSM SHALL have the states IDLE, ARMED, FIRE and HOLDOFF; armed=1 only in ARMED.
REQ-017 IDLE->ARMED SHALL occur on arm=1 with cfg_enable=1; arm SHALL be ignored in any other state.
REQ-018 In ARMED with OR mode, any enabled qualifying channel SHALL cause the transition to FIRE.
REQ-019 In AND mode, per-channel sticky hits SHALL set on qualification and SHALL cause the transition to FIRE once all enabled channels are set; hits SHALL clear on entering ARMED.
REQ-020 FIRE SHALL last one cycle: trigger_out=1, trig_ch is latched, trig_count is incremented (saturating at 0xFFFF); it SHALL then go to HOLDOFF.
REQ-021 HOLDOFF SHALL count cfg_holdoff clocks and then go to ARMED if cfg_auto_rearm=1, otherwise to IDLE; cfg_holdoff=0 SHALL leave HOLDOFF after one cycle.
REQ-022 Qualifications outside ARMED SHALL be discarded.
REQ-023 If no channel is enabled, FIRE SHALL never occur.
REQ-024 Latency from the source edge to trigger_out SHALL be 4 clocks (2 sync, 1 edge/qualify, 1 FIRE).
REQ-025 cfg_enable=0 SHALL force IDLE and clear the width counters, the hits and the prescaler; trig_ch and trig_count SHALL be held.

Reset
REQ-026 rst_sync=1 SHALL, at the next clk edge, set the FSM to IDLE and zero the synchronizers, counters, hits, the prescaler, trigger_out, armed, trig_ch and trig_count.
REQ-027 Reset during FIRE or HOLDOFF SHALL abort without emitting a trigger_out pulse.

Structure
REQ-028 The FSM state enum and the type encodings 0..4 SHALL be placed in the package scarf_trigger_pkg.
REQ-029 The per-channel synchronizer, edge detector, width counter and qualifier SHALL be the sub-module trigger_qual, instantiated NUM_CH times.

Verification
REQ-030 Type 1 test: cfg_min=5, prescale 0, channel 0 enabled, armed, 3-clock positive pulse -> trigger_out 4 clocks after the falling edge, trig_ch=0001, trig_count=1.
REQ-031 Type 3 test: cfg_min=4, cfg_max=10, pulses of 4, 7 and 11 ticks -> only the 7-tick pulse triggers.
REQ-032 Timeout test: type 2, cfg_timeout=1, cfg_min=8, prescale 3, held-high source -> trigger when the counter reaches 9 (36 clocks), no second trigger at the falling edge.
REQ-033 AND test: channels 0 and 2 enabled, qualifying pulses 50 clocks apart -> single trigger after the second, trig_ch=0100.
REQ-034 Holdoff test: cfg_holdoff=20, auto-rearm, qualifying pulses 10 and 30 clocks after the first trigger -> first discarded, second triggers, trig_count=2.
REQ-035 Reset test: rst_sync asserted during HOLDOFF -> IDLE, armed=0, trig_count=0, no trigger_out.

Source files
------------

// File: rtl/scarf_trigger_pkg.sv
// Shared types for the multi-channel pulse-width trigger: the FSM state
// encoding, the qualifier type codes and the width comparison helper.
package scarf_trigger_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_FIRE    = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_t;

   // Qualifier type codes; codes 5..7 are reserved and never qualify.
   localparam logic [2:0] TYPE_ANY     = 3'd0;  // any completed pulse
   localparam logic [2:0] TYPE_SHORT   = 3'd1;  // W < min
   localparam logic [2:0] TYPE_LONG    = 3'd2;  // W > min
   localparam logic [2:0] TYPE_INSIDE  = 3'd3;  // min < W < max
   localparam logic [2:0] TYPE_OUTSIDE = 3'd4;  // W < min or W > max

   // Decide whether a completed pulse of width w qualifies under qtype.
   // Arguments are widened to 32 bits so any counter width up to 32 fits.
   function automatic logic width_match(input logic [2:0]  qtype,
                                        input logic [31:0] w,
                                        input logic [31:0] w_min,
                                        input logic [31:0] w_max);
      logic hit;
      hit = 1'b0;
      case (qtype)
         TYPE_ANY:     hit = 1'b1;
         TYPE_SHORT:   hit = (w < w_min);
         TYPE_LONG:    hit = (w > w_min);
         TYPE_INSIDE:  hit = (w > w_min) && (w < w_max);
         TYPE_OUTSIDE: hit = (w < w_min) || (w > w_max);
         default:      hit = 1'b0;
      endcase
      width_match = hit;
   endfunction

endpackage

// File: rtl/trigger_qual.sv
// One trigger channel: two-flop synchronizer, polarity fix-up, edge
// detection, tick-based pulse width counter and the width qualifier.
// The qualification is registered so the path from synchronizer to the
// FSM has exactly one stage of edge/qualify logic.
module trigger_qual
   import scarf_trigger_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst_sync,
   input  logic             enable,
   input  logic             src,
   input  logic             positive,
   input  logic             tick,
   input  logic [2:0]       cfg_type,
   input  logic [CNT_W-1:0] cfg_min,
   input  logic [CNT_W-1:0] cfg_max,
   input  logic             cfg_timeout,
   output logic             qual
);

   localparam logic [CNT_W-1:0] WIDTH_MAX = '1;
   localparam logic [CNT_W-1:0] WIDTH_ONE = CNT_W'(1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             level_prev_reg;
   logic             to_done_reg;
   logic             qual_reg;
   logic [CNT_W-1:0] width_reg;

   logic             level;
   logic             rise;
   logic             fall;
   logic             held;
   logic             timeout_mode;
   logic [CNT_W-1:0] threshold;
   logic             timeout_hit;
   logic             edge_hit;

   // Active level is always 1 after this point, whatever the source polarity.
   assign level = positive ? sync2_reg : ~sync2_reg;
   assign rise  = level & ~level_prev_reg;
   assign fall  = ~level & level_prev_reg;
   assign held  = level & level_prev_reg;

   // Timeout mode only makes sense for the "too long" style qualifiers.
   assign timeout_mode = cfg_timeout &&
                         ((cfg_type == TYPE_LONG) || (cfg_type == TYPE_OUTSIDE));
   assign threshold    = (cfg_type == TYPE_LONG) ? cfg_min : cfg_max;

   // Fire while the pulse is still active, once, as soon as it is too long.
   // The rise cycle is excluded because the counter still holds the last width.
   assign timeout_hit = timeout_mode && held && !to_done_reg && (width_reg > threshold);

   // A pulse already reported by timeout must not qualify again at its end.
   assign edge_hit = fall && !(timeout_mode && to_done_reg) &&
                     width_match(cfg_type, 32'(width_reg), 32'(cfg_min), 32'(cfg_max));

   assign qual = qual_reg;

   // Two-flop synchronizer and previous-level register for edge detection.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         sync1_reg      <= 1'b0;
         sync2_reg      <= 1'b0;
         level_prev_reg <= 1'b0;
      end else begin
         sync1_reg      <= src;
         sync2_reg      <= sync1_reg;
         level_prev_reg <= level;
      end
   end

   // Width counter: restarts on the active edge (counting that cycle's tick),
   // then counts ticks while active and saturates at all-ones.
   always_ff @(posedge clk) begin
      if (rst_sync || !enable) begin
         width_reg <= '0;
      end else if (rise) begin
         width_reg <= tick ? WIDTH_ONE : '0;
      end else if (level && tick && (width_reg != WIDTH_MAX)) begin
         width_reg <= width_reg + WIDTH_ONE;
      end
   end

   // Timeout-reported flag (per pulse) and the registered qualification.
   always_ff @(posedge clk) begin
      if (rst_sync || !enable) begin
         to_done_reg <= 1'b0;
         qual_reg    <= 1'b0;
      end else begin
         if (rise) begin
            to_done_reg <= 1'b0;
         end else if (timeout_hit) begin
            to_done_reg <= 1'b1;
         end
         qual_reg <= timeout_hit | edge_hit;
      end
   end

endmodule

// File: rtl/scarf_trigger_mc.sv
// Multi-channel pulse-width trigger. Channel qualifiers feed a small
// IDLE/ARMED/FIRE/HOLDOFF controller that combines them in OR or AND mode,
// emits a one-cycle trigger, records the causing channels and counts triggers.
module scarf_trigger_mc
   import scarf_trigger_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16,
   parameter int PRESC_W = 8
)
(
   input  logic               clk,
   input  logic               rst_sync,
   input  logic [NUM_CH-1:0]  trig_src,
   input  logic               cfg_enable,
   input  logic [NUM_CH-1:0]  cfg_ch_en,
   input  logic [NUM_CH-1:0]  cfg_positive,
   input  logic [2:0]         cfg_type,
   input  logic [CNT_W-1:0]   cfg_min,
   input  logic [CNT_W-1:0]   cfg_max,
   input  logic [PRESC_W-1:0] cfg_prescale,
   input  logic               cfg_timeout,
   input  logic               cfg_and,
   input  logic [CNT_W-1:0]   cfg_holdoff,
   input  logic               cfg_auto_rearm,
   input  logic               arm,
   output logic               trigger_out,
   output logic               armed,
   output logic [NUM_CH-1:0]  trig_ch,
   output logic [15:0]        trig_count
);

   state_t              state_reg;
   state_t              state_next;
   logic [PRESC_W-1:0]  presc_reg;
   logic [NUM_CH-1:0]   hits_reg;
   logic [CNT_W-1:0]    hold_cnt_reg;
   logic [NUM_CH-1:0]   trig_ch_reg;
   logic [15:0]         trig_count_reg;

   logic                tick;
   logic [NUM_CH-1:0]   qual_vec;
   logic [NUM_CH-1:0]   en_qual;
   logic                all_hit;
   logic [CNT_W:0]      hold_plus;
   logic                hold_done;
   logic                fire_now;

   // Tick on the last count of each prescaler period; ">=" keeps it safe
   // if the period is shortened while the counter is above the new limit.
   assign tick = cfg_enable && (presc_reg >= cfg_prescale);

   // Prescaler for the width-counter time base.
   always_ff @(posedge clk) begin
      if (rst_sync || !cfg_enable) begin
         presc_reg <= '0;
      end else if (tick) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_reg + PRESC_W'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         trigger_qual #(
            .CNT_W (CNT_W)
         ) u_qual (
            .clk         (clk),
            .rst_sync    (rst_sync),
            .enable      (cfg_enable),
            .src         (trig_src[gi]),
            .positive    (cfg_positive[gi]),
            .tick        (tick),
            .cfg_type    (cfg_type),
            .cfg_min     (cfg_min),
            .cfg_max     (cfg_max),
            .cfg_timeout (cfg_timeout),
            .qual        (qual_vec[gi])
         );
      end
   endgenerate

   assign en_qual = qual_vec & cfg_ch_en;

   // AND mode completes in the same cycle the last missing channel qualifies.
   // An empty enable mask can never complete.
   assign all_hit = (|cfg_ch_en) &&
                    (((hits_reg | en_qual) & cfg_ch_en) == cfg_ch_en);

   // HOLDOFF lasts max(cfg_holdoff, 1) cycles.
   assign hold_plus = {1'b0, hold_cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
   assign hold_done = (hold_plus >= {1'b0, cfg_holdoff});

   assign fire_now = (state_reg == ST_ARMED) && (state_next == ST_FIRE);

   // Next-state logic; disabling the block overrides every transition.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (arm) begin
               state_next = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (cfg_and ? all_hit : (|en_qual)) begin
               state_next = ST_FIRE;
            end
         end
         ST_FIRE: begin
            state_next = ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            if (hold_done) begin
               state_next = cfg_auto_rearm ? ST_ARMED : ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (!cfg_enable) begin
         state_next = ST_IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Sticky AND-mode hits: only collected while ARMED, so they are empty on
   // every entry to ARMED and qualifications in other states are dropped.
   always_ff @(posedge clk) begin
      if (rst_sync || !cfg_enable || (state_reg != ST_ARMED)) begin
         hits_reg <= '0;
      end else begin
         hits_reg <= hits_reg | en_qual;
      end
   end

   // Holdoff cycle counter, running only inside HOLDOFF.
   always_ff @(posedge clk) begin
      if (rst_sync || (state_reg != ST_HOLDOFF)) begin
         hold_cnt_reg <= '0;
      end else begin
         hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
      end
   end

   // Record the causing channels and count the trigger as FIRE is entered,
   // so both are already valid while trigger_out is high.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         trig_ch_reg    <= '0;
         trig_count_reg <= '0;
      end else if (fire_now) begin
         trig_ch_reg <= en_qual;
         if (trig_count_reg != 16'hFFFF) begin
            trig_count_reg <= trig_count_reg + 16'd1;
         end
      end
   end

   assign trigger_out = (state_reg == ST_FIRE);
   assign armed       = (state_reg == ST_ARMED);
   assign trig_ch     = trig_ch_reg;
   assign trig_count  = trig_count_reg;

endmodule

// File: tb/tb_scarf_trigger_mc.sv
// Directed bench for scarf_trigger_mc: width qualifiers, timeout mode,
// AND combining, holdoff, enable and reset behaviour.
module tb_scarf_trigger_mc;
   import scarf_trigger_pkg::*;

   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 16;
   localparam int PRESC_W = 8;

   logic               clk;
   logic               rst_sync;
   logic [NUM_CH-1:0]  trig_src;
   logic               cfg_enable;
   logic [NUM_CH-1:0]  cfg_ch_en;
   logic [NUM_CH-1:0]  cfg_positive;
   logic [2:0]         cfg_type;
   logic [CNT_W-1:0]   cfg_min;
   logic [CNT_W-1:0]   cfg_max;
   logic [PRESC_W-1:0] cfg_prescale;
   logic               cfg_timeout;
   logic               cfg_and;
   logic [CNT_W-1:0]   cfg_holdoff;
   logic               cfg_auto_rearm;
   logic               arm;
   logic               trigger_out;
   logic               armed;
   logic [NUM_CH-1:0]  trig_ch;
   logic [15:0]        trig_count;

   int checks = 0;
   int errors = 0;

   scarf_trigger_mc #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
   ) dut (
      .clk            (clk),
      .rst_sync       (rst_sync),
      .trig_src       (trig_src),
      .cfg_enable     (cfg_enable),
      .cfg_ch_en      (cfg_ch_en),
      .cfg_positive   (cfg_positive),
      .cfg_type       (cfg_type),
      .cfg_min        (cfg_min),
      .cfg_max        (cfg_max),
      .cfg_prescale   (cfg_prescale),
      .cfg_timeout    (cfg_timeout),
      .cfg_and        (cfg_and),
      .cfg_holdoff    (cfg_holdoff),
      .cfg_auto_rearm (cfg_auto_rearm),
      .arm            (arm),
      .trigger_out    (trigger_out),
      .armed          (armed),
      .trig_ch        (trig_ch),
      .trig_count     (trig_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) $display("check %-16s ok  value=%0h", tag, obs);
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step(1);
      arm = 1'b0;
   endtask

   // Drive an n-clock active-high pulse on one channel.
   task automatic pulse(input int ch, input int n);
      trig_src[ch] = 1'b1;
      step(n);
      trig_src[ch] = 1'b0;
   endtask

   // Step up to budget edges, stopping at the first trigger_out; lat is the
   // number of edges taken.
   task automatic wait_trig(input int budget, output bit got, output int lat);
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < budget && !got; i++) begin
         step(1);
         lat++;
         if (trigger_out === 1'b1) got = 1'b1;
      end
   endtask

   bit got;
   int lat;

   initial begin
      rst_sync       = 1'b1;
      trig_src       = '0;
      cfg_enable     = 1'b1;
      cfg_ch_en      = 4'b0001;
      cfg_positive   = 4'b1111;
      cfg_type       = TYPE_SHORT;
      cfg_min        = 16'd5;
      cfg_max        = 16'd0;
      cfg_prescale   = 8'd0;
      cfg_timeout    = 1'b0;
      cfg_and        = 1'b0;
      cfg_holdoff    = 16'd0;
      cfg_auto_rearm = 1'b0;
      arm            = 1'b0;
      step(3);
      rst_sync = 1'b0;
      step(1);

      // Reset state
      check("rst_trigger", 32'(trigger_out), 32'd0);
      check("rst_armed", 32'(armed), 32'd0);
      check("rst_count", 32'(trig_count), 32'd0);
      check("rst_ch", 32'(trig_ch), 32'd0);

      // Type 1: 3-clock pulse with min 5 qualifies, 4 clocks after its fall
      do_arm();
      check("arm_armed", 32'(armed), 32'd1);
      pulse(0, 3);
      step(3);
      check("t1_lat3_quiet", 32'(trigger_out), 32'd0);
      step(1);
      check("t1_lat4_fire", 32'(trigger_out), 32'd1);
      check("t1_ch", 32'(trig_ch), 32'h1);
      check("t1_count", 32'(trig_count), 32'd1);
      step(3);
      check("t1_idle", 32'(armed), 32'd0);

      // Type 3: min 4, max 10; only the 7-tick pulse is strictly inside
      cfg_type = TYPE_INSIDE;
      cfg_min  = 16'd4;
      cfg_max  = 16'd10;
      do_arm();
      pulse(0, 4);
      wait_trig(10, got, lat);
      check("t3_w4_none", 32'(got), 32'd0);
      pulse(0, 7);
      wait_trig(10, got, lat);
      check("t3_w7_fire", 32'(got), 32'd1);
      check("t3_w7_lat", 32'(lat), 32'd4);
      check("t3_w7_count", 32'(trig_count), 32'd2);
      step(3);
      do_arm();
      pulse(0, 11);
      wait_trig(10, got, lat);
      check("t3_w11_none", 32'(got), 32'd0);
      check("t3_w11_count", 32'(trig_count), 32'd2);

      // Timeout: type 2, min 8, tick every 4 clocks, source held high
      cfg_type       = TYPE_LONG;
      cfg_min        = 16'd8;
      cfg_timeout    = 1'b1;
      cfg_prescale   = 8'd3;
      cfg_auto_rearm = 1'b1;
      trig_src[0]    = 1'b1;
      wait_trig(60, got, lat);
      check("to_fire", 32'(got), 32'd1);
      check("to_lat_window", 32'(lat >= 36 && lat <= 41), 32'd1);
      step(10);
      trig_src[0] = 1'b0;
      wait_trig(15, got, lat);
      check("to_no_second", 32'(got), 32'd0);
      check("to_count", 32'(trig_count), 32'd3);

      // Disabling forces IDLE but keeps trig_ch / trig_count; arm is ignored
      cfg_enable = 1'b0;
      step(2);
      check("dis_armed", 32'(armed), 32'd0);
      check("dis_count_held", 32'(trig_count), 32'd3);
      check("dis_ch_held", 32'(trig_ch), 32'h1);
      do_arm();
      check("dis_arm_ignored", 32'(armed), 32'd0);
      cfg_enable     = 1'b1;
      cfg_timeout    = 1'b0;
      cfg_prescale   = 8'd0;
      cfg_auto_rearm = 1'b0;
      step(1);

      // AND mode: channels 0 and 2, pulses 50 clocks apart
      cfg_type  = TYPE_ANY;
      cfg_and   = 1'b1;
      cfg_ch_en = 4'b0101;
      do_arm();
      pulse(0, 2);
      wait_trig(50, got, lat);
      check("and_first_none", 32'(got), 32'd0);
      pulse(2, 2);
      wait_trig(10, got, lat);
      check("and_fire", 32'(got), 32'd1);
      check("and_lat", 32'(lat), 32'd4);
      check("and_ch", 32'(trig_ch), 32'h4);
      check("and_count", 32'(trig_count), 32'd4);
      step(3);

      // No enabled channel: OR mode never fires
      cfg_and   = 1'b0;
      cfg_ch_en = 4'b0000;
      do_arm();
      pulse(0, 2);
      wait_trig(10, got, lat);
      check("noch_none", 32'(got), 32'd0);

      // Holdoff 20 with auto-rearm: pulse at +10 dropped, pulse at +30 fires
      cfg_ch_en      = 4'b0001;
      cfg_holdoff    = 16'd20;
      cfg_auto_rearm = 1'b1;
      pulse(0, 2);
      wait_trig(10, got, lat);
      check("ho_first_fire", 32'(got), 32'd1);
      check("ho_first_count", 32'(trig_count), 32'd5);
      step(10);
      pulse(0, 2);
      wait_trig(18, got, lat);
      check("ho_discard", 32'(got), 32'd0);
      pulse(0, 2);
      wait_trig(10, got, lat);
      check("ho_second_fire", 32'(got), 32'd1);
      check("ho_count", 32'(trig_count), 32'd6);

      // Reset in HOLDOFF: back to IDLE, counters cleared, no trigger
      step(5);
      rst_sync = 1'b1;
      step(1);
      rst_sync = 1'b0;
      check("rh_trigger", 32'(trigger_out), 32'd0);
      check("rh_armed", 32'(armed), 32'd0);
      check("rh_count", 32'(trig_count), 32'd0);
      check("rh_ch", 32'(trig_ch), 32'd0);
      wait_trig(30, got, lat);
      check("rh_no_trigger", 32'(got), 32'd0);
      check("rh_still_idle", 32'(armed), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
